i2s_tdm_tx: RTL and testbench

Parametrised audio serial transmitter for the DAC path: buffers interleaved PCM samples in an internal FIFO and serialises them as I2S (2 channels) or TDM (4/8 channels). It runs entirely on MasterCLK, generates DAC_I2S_CLK/WS/DATA itself, and supports both I2S (1-bit delayed) and left-justified framing. It adds configurable sample and slot width, frame-aligned FIFO buffering, an enable gate and underrun reporting.

---
 rtl/i2s_tdm_tx_if.sv | 11 +
 rtl/i2s_tdm_tx.sv | 149 ++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_tdm_tx_if.sv
// rtl/i2s_tdm_tx_if.sv - PCM sample write port for the I2S/TDM transmitter
interface i2s_tdm_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] SampleData;
  logic                    SampleValid;
  logic                    SampleReady;

  modport master (output SampleData, output SampleValid, input SampleReady);
  modport slave  (input SampleData, input SampleValid, output SampleReady);
endinterface

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - FIFO-buffered I2S / left-justified TDM serialiser for the DAC path
module i2s_tdm_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 16,
  parameter int CHANNELS     = 2,
  parameter int CLK_DIV      = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int MODE         = 0
) (
  input  logic                        MasterCLK,
  input  logic                        Reset,
  input  logic                        Enable,
  i2s_tdm_tx_if.slave                 smp,
  output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
  output logic                        Underrun,
  output logic                        DAC_I2S_CLK,
  output logic                        DAC_I2S_WS,
  output logic                        DAC_I2S_DATA
);

  localparam int FRAME_BITS = CHANNELS * SLOT_WIDTH;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int FW = CHANNELS * SAMPLE_WIDTH;
  localparam int IW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    wr_en, can_pop, pop;
  logic [FW-1:0]           fifo_frame;

  assign smp.SampleReady = (FifoLevel < LW'(FIFO_DEPTH));
  assign wr_en           = smp.SampleValid && smp.SampleReady;
  assign can_pop         = (FifoLevel >= LW'(CHANNELS));

  // Slot 0 occupies the MSBs so the frame vector reads in transmit order.
  always_comb begin
    fifo_frame = '0;
    for (int c = 0; c < CHANNELS; c++)
      fifo_frame[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = mem[rd_ptr + PW'(c)];
  end

  always_ff @(posedge MasterCLK) begin
    if (wr_en) mem[wr_ptr] <= smp.SampleData;
  end

  always_ff @(posedge MasterCLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FifoLevel <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(CHANNELS);
      FifoLevel <= FifoLevel + LW'(wr_en) - (pop ? LW'(CHANNELS) : '0);
    end
  end

  function automatic logic frame_bit(input logic [FW-1:0] f, input logic [BW-1:0] p);
    int unsigned pi, s, k;
    pi = 32'(p);
    s  = pi / SLOT_WIDTH;
    k  = pi % SLOT_WIDTH;
    if (k >= SAMPLE_WIDTH) return 1'b0;
    return f[IW'(FW - 1 - (s * SAMPLE_WIDTH + k))];
  endfunction

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, nbit, pos;
  logic [FW-1:0] frame_q, frame_next, src;
  logic          adv, load;

  always_comb begin
    adv  = 1'b0;
    nbit = bit_cnt;
    if (!active) begin
      adv  = 1'b1;
      nbit = '0;
    end else if (DAC_I2S_CLK && div_cnt == DW'(CLK_DIV - 1)) begin
      adv  = 1'b1;
      nbit = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + BW'(1);
    end
    load = Enable && adv && (nbit == '0);
    pop  = load && can_pop;
    frame_next = frame_q;
    if (load) frame_next = can_pop ? fifo_frame : '0;
    // In I2S mode bit 0 of a frame still carries the previous frame's last bit.
    if (MODE == 0) begin
      pos = (nbit == '0) ? BW'(FRAME_BITS - 1) : nbit - BW'(1);
      src = (nbit == '0) ? frame_q : frame_next;
    end else begin
      pos = nbit;
      src = frame_next;
    end
  end

  always_ff @(posedge MasterCLK or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_q      <= '0;
      Underrun     <= 1'b0;
      DAC_I2S_CLK  <= 1'b0;
      DAC_I2S_WS   <= 1'b0;
      DAC_I2S_DATA <= 1'b0;
    end else if (!Enable) begin
      active       <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_q      <= '0;
      Underrun     <= 1'b0;
      DAC_I2S_CLK  <= 1'b0;
      DAC_I2S_WS   <= 1'b0;
      DAC_I2S_DATA <= 1'b0;
    end else begin
      active   <= 1'b1;
      Underrun <= load && !can_pop;
      if (active) begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt     <= '0;
          DAC_I2S_CLK <= ~DAC_I2S_CLK;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
      if (adv) begin
        bit_cnt      <= nbit;
        frame_q      <= frame_next;
        DAC_I2S_WS   <= (nbit >= BW'(FRAME_BITS / 2));
        DAC_I2S_DATA <= frame_bit(src, pos);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb/tb_i2s_tdm_tx.sv - directed table-driven bench for i2s_tdm_tx (I2S and LJ-TDM instances)
module tb_i2s_tdm_tx;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [3:0] lvl_a, lvl_b;
  logic       und_a, clk_a, ws_a, dat_a;
  logic       und_b, clk_b, ws_b, dat_b;

  int checks   = 0;
  int failures = 0;

  i2s_tdm_tx_if #(.SAMPLE_WIDTH(16)) ifa ();
  i2s_tdm_tx_if #(.SAMPLE_WIDTH(16)) ifb ();

  i2s_tdm_tx #(
    .SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(2),
    .CLK_DIV(2), .FIFO_DEPTH(8), .MODE(0)
  ) dut_a (
    .MasterCLK(clk), .Reset(rst_n), .Enable(en_a), .smp(ifa),
    .FifoLevel(lvl_a), .Underrun(und_a),
    .DAC_I2S_CLK(clk_a), .DAC_I2S_WS(ws_a), .DAC_I2S_DATA(dat_a)
  );

  i2s_tdm_tx #(
    .SAMPLE_WIDTH(16), .SLOT_WIDTH(24), .CHANNELS(4),
    .CLK_DIV(1), .FIFO_DEPTH(8), .MODE(1)
  ) dut_b (
    .MasterCLK(clk), .Reset(rst_n), .Enable(en_b), .smp(ifb),
    .FifoLevel(lvl_b), .Underrun(und_b),
    .DAC_I2S_CLK(clk_b), .DAC_I2S_WS(ws_b), .DAC_I2S_DATA(dat_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Samples one frame: each bit once while the bit clock is low and once while high.
  task automatic grab(input bit b, input int nbits, input int half,
                      output logic [95:0] d, output logic [95:0] w,
                      output int clk_err, output int un, output logic [3:0] lvl0);
    d = '0; w = '0; clk_err = 0; un = 0;
    lvl0 = b ? lvl_b : lvl_a;
    for (int n = 0; n < nbits; n++) begin
      d[nbits-1-n] = b ? dat_b : dat_a;
      w[nbits-1-n] = b ? ws_b : ws_a;
      if ((b ? clk_b : clk_a) !== 1'b0) clk_err++;
      if ((b ? und_b : und_a) === 1'b1) un++;
      repeat (half) @(negedge clk);
      if ((b ? clk_b : clk_a) !== 1'b1) clk_err++;
      if ((b ? und_b : und_a) === 1'b1) un++;
      repeat (half) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_d;
    int          exp_un;
    logic [3:0]  exp_lvl;
  } frame_vec_t;

  frame_vec_t   tbl [5];
  logic [95:0]  d, w;
  int           clk_err, un;
  logic [3:0]   lvl0;
  logic [15:0]  wv;
  bit           seen;

  initial begin
    tbl[0] = '{16'hA5F0, 16'h0F0F, 32'h52F80787, 0, 4'd6};
    tbl[1] = '{16'h1234, 16'h8001, 32'h891A4000, 0, 4'd4};
    tbl[2] = '{16'hFFFF, 16'h0000, 32'hFFFF8000, 0, 4'd2};
    tbl[3] = '{16'h0001, 16'hC3C3, 32'h0000E1E1, 0, 4'd0};
    tbl[4] = '{16'h0000, 16'h0000, 32'h80000000, 1, 4'd0};

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    ifa.SampleValid = 1'b0; ifa.SampleData = '0;
    ifb.SampleValid = 1'b0; ifb.SampleData = '0;
    repeat (3) @(negedge clk);
    chk("reset_lvl_a", 96'(lvl_a), 96'd0);
    chk("reset_rdy_a", 96'(ifa.SampleReady), 96'd1);
    chk("reset_out_a", 96'({clk_a, ws_a, dat_a, und_a}), 96'd0);
    chk("reset_out_b", 96'({clk_b, ws_b, dat_b, und_b, lvl_b}), 96'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Left-justified TDM: 4 x 24-bit slots carrying 16-bit samples.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: wv = 16'h8001;
        1: wv = 16'h7FFE;
        2: wv = 16'hFFFF;
        default: wv = 16'h0000;
      endcase
      ifb.SampleData = wv; ifb.SampleValid = 1'b1;
      @(negedge clk);
    end
    ifb.SampleValid = 1'b0;
    chk("tdm_fill_lvl", 96'(lvl_b), 96'd4);
    en_b = 1'b1;
    @(negedge clk);
    grab(1'b1, 96, 1, d, w, clk_err, un, lvl0);
    chk("tdm_f0_data", d, 96'h8001007FFE00FFFF00000000);
    chk("tdm_f0_ws", w, 96'h000000000000FFFFFFFFFFFF);
    chk("tdm_f0_bclk", 96'(clk_err), 96'd0);
    chk("tdm_f0_un", 96'(un), 96'd0);
    chk("tdm_f0_lvl", 96'(lvl0), 96'd0);
    grab(1'b1, 96, 1, d, w, clk_err, un, lvl0);
    chk("tdm_f1_data", d, 96'd0);
    chk("tdm_f1_un", 96'(un), 96'd1);
    repeat (120) @(negedge clk);
    chk("tdm_ws_mid", 96'(ws_b), 96'd1);
    en_b = 1'b0;
    @(negedge clk);
    chk("tdm_disable_idle", 96'({clk_b, ws_b, dat_b}), 96'd0);

    // Fill the I2S FIFO past capacity while disabled.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) wv = 16'hDEAD;
      else        wv = (i % 2 == 0) ? tbl[i/2].l : tbl[i/2].r;
      ifa.SampleData = wv; ifa.SampleValid = 1'b1;
      chk($sformatf("fill_ready_%0d", i), 96'(ifa.SampleReady), (i < 8) ? 96'd1 : 96'd0);
      @(negedge clk);
    end
    ifa.SampleValid = 1'b0;
    chk("full_lvl", 96'(lvl_a), 96'd8);
    chk("full_rdy", 96'(ifa.SampleReady), 96'd0);

    en_a = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      grab(1'b0, 32, 2, d, w, clk_err, un, lvl0);
      chk($sformatf("i2s_f%0d_data", f), 96'(d[31:0]), 96'(tbl[f].exp_d));
      chk($sformatf("i2s_f%0d_ws", f), 96'(w[31:0]), 96'h0000FFFF);
      chk($sformatf("i2s_f%0d_bclk", f), 96'(clk_err), 96'd0);
      chk($sformatf("i2s_f%0d_un", f), 96'(un), 96'(tbl[f].exp_un));
      chk($sformatf("i2s_f%0d_lvl", f), 96'(lvl0), 96'(tbl[f].exp_lvl));
    end

    // Two samples mid-frame, then a write coinciding with the frame-load pop.
    ifa.SampleData = 16'h1111; ifa.SampleValid = 1'b1;
    @(negedge clk);
    ifa.SampleData = 16'h2222;
    @(negedge clk);
    ifa.SampleValid = 1'b0;
    chk("pre_pop_lvl", 96'(lvl_a), 96'd2);
    repeat (125) @(negedge clk);
    ifa.SampleData = 16'h3333; ifa.SampleValid = 1'b1;
    @(negedge clk);
    ifa.SampleValid = 1'b0;
    chk("wr_pop_lvl", 96'(lvl_a), 96'd1);
    chk("wr_pop_un", 96'(und_a), 96'd0);
    repeat (128) @(negedge clk);
    chk("partial_un", 96'(und_a), 96'd1);
    chk("partial_lvl", 96'(lvl_a), 96'd1);

    // Bit 7, bit clock high: assert reset mid-frame.
    repeat (30) @(negedge clk);
    chk("pre_rst_bclk", 96'(clk_a), 96'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_lvl", 96'(lvl_a), 96'd0);
    chk("rst_out", 96'({clk_a, ws_a, dat_a, und_a}), 96'd0);
    chk("rst_rdy", 96'(ifa.SampleReady), 96'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (und_a === 1'b1) seen = 1'b1;
    end
    chk("post_rst_underrun", 96'(seen), 96'd1);
    chk("post_rst_lvl", 96'(lvl_a), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
